// File: rtl/hex_display_scan_ctrl.sv
// hex_display_scan_ctrl: time-multiplexed 7-segment scan controller fed by a shifting nibble buffer.
// Define HEX_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module hex_display_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int IW = $clog2(NUM_DIGITS),
  localparam int CW = $clog2(SCAN_DIV)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [3:0]            in_nibble,
  output logic                  in_ready,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [IW-1:0]         scan_idx
);
  typedef enum logic {BLANK, DRIVE} phase_t;
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  phase_t phase_q, phase_d;
  logic [CW-1:0] cnt;
  logic [3:0] nib [NUM_DIGITS];
  logic wrap, hide;
  logic [6:0] seg_d;
  logic [NUM_DIGITS-1:0] sel_d;
  assign in_ready = !reset && !clear;
  assign wrap = cnt == CW'(SCAN_DIV - 1);
  always_comb phase_d = wrap ? BLANK : (cnt == CW'(BLANK_CYCLES - 1)) ? DRIVE : phase_q;
  always_ff @(posedge clk)
    if (reset) phase_q <= BLANK;
    else phase_q <= phase_d;
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      scan_idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
  always_ff @(posedge clk)
    if (reset || clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) nib[i] <= '0;
    end else if (in_valid && in_ready) begin
      nib[0] <= in_nibble;
      for (int i = 1; i < NUM_DIGITS; i++) nib[i] <= nib[i-1];
    end
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic z;
  // lz[i] set when nib[i] and every higher digit are zero
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z && (nib[i] == 4'd0);
      lz[i] = z;
    end
  end
  assign hide = lz[scan_idx];
`else
  assign hide = 1'b0;
`endif
  always_comb begin
    seg_d = (phase_q == DRIVE && !hide) ? FONT[nib[scan_idx]] : 7'h7F;
    sel_d = (phase_q == DRIVE) ? ~(NUM_DIGITS'(1) << scan_idx) : '1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      seg_out <= 7'h7F;
      digit_sel <= '1;
    end else begin
      seg_out <= seg_d;
      digit_sel <= sel_d;
    end
endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// tb_hex_display_scan_ctrl: directed plus random stimulus against a cycle-count based reference model.
module tb_hex_display_scan_ctrl;
  localparam int N = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic clk = 0, reset = 0, clear = 0, in_valid = 0;
  logic [3:0] in_nibble = 0;
  logic in_ready;
  logic [6:0] seg_out;
  logic [N-1:0] digit_sel;
  logic [1:0] scan_idx;
  int n_pass = 0, n_total = 0;
  int ticks = 0;
  logic [3:0] mbuf [N];

  hex_display_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_nibble(in_nibble),
    .in_ready(in_ready), .seg_out(seg_out), .digit_sel(digit_sel), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic hidden(input int d);
    logic z = 1'b1;
    if (d == 0) return 1'b0;
    for (int j = d; j < N; j++) z = z && (mbuf[j] == 4'd0);
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    return z;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic r, input logic c, input logic v, input logic [3:0] n);
    logic [6:0] es;
    logic [N-1:0] ed;
    int cpos, slot;
    reset = r; clear = c; in_valid = v; in_nibble = n;
    #1;
    chk("in_ready", 16'(in_ready), 16'(!r && !c));
    cpos = ticks % SD;
    slot = (ticks / SD) % N;
    es = 7'h7F;
    ed = '1;
    if (!r && cpos >= BC) begin
      ed = ~(N'(1) << slot);
      es = hidden(slot) ? 7'h7F : FONT[mbuf[slot]];
    end
    if (r) begin
      for (int i = 0; i < N; i++) mbuf[i] = 0;
      ticks = 0;
    end else begin
      if (c) for (int i = 0; i < N; i++) mbuf[i] = 0;
      else if (v) begin
        for (int i = N - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
        mbuf[0] = n;
      end
      ticks++;
    end
    @(posedge clk);
    #1;
    chk("seg_out", 16'(seg_out), 16'(es));
    chk("digit_sel", 16'(digit_sel), 16'(ed));
    chk("scan_idx", 16'(scan_idx), 16'((ticks / SD) % N));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mbuf[i] = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'h7);
    idle(40);
    step(0, 0, 1, 4'h1);
    step(0, 0, 1, 4'h2);
    step(0, 0, 1, 4'h3);
    step(0, 0, 1, 4'h4);
    idle(32);
    step(0, 0, 1, 4'hA);
    idle(32);
    step(0, 1, 1, 4'hF);
    idle(32);
    while (ticks % (SD * N) != 2 * SD + 5) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(12);
    step(1, 0, 0, 0);
    idle(4);
    step(0, 0, 1, 4'h8);
    idle(8);
    step(0, 0, 1, 4'h0);
    step(0, 0, 1, 4'h0);
    step(0, 0, 1, 4'h5);
    idle(32);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0, 4'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
